run_controller: RTL

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 119 +++++++++++
 1 files changed

// File: rtl/run_controller.sv
// Run sequencer for a processor core: holds the core in reset, lets it run
// under a cycle budget, and reports completion or timeout until cleared.
module run_controller #(
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 300,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt,
    input  logic             clear,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0]       RST_LOAD   = 8'(RST_CYCLES);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MAX_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [7:0]       rst_cnt_reg, rst_cnt_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             core_rst_reg, core_rst_next;
    logic             running_reg, running_next;
    logic             done_reg, done_next;
    logic             timeout_reg, timeout_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            rst_cnt_reg  <= '0;
            count_reg    <= '0;
            core_rst_reg <= 1'b1;
            running_reg  <= 1'b0;
            done_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rst_cnt_reg  <= rst_cnt_next;
            count_reg    <= count_next;
            core_rst_reg <= core_rst_next;
            running_reg  <= running_next;
            done_reg     <= done_next;
            timeout_reg  <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rst_cnt_next = rst_cnt_reg;
        count_next   = count_reg;
        timeout_next = timeout_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = RESET;
                    rst_cnt_next = RST_LOAD;
                end
            end
            RESET: begin
                // The loaded value counts the RESET cycles themselves, so leave on the last one.
                if (rst_cnt_reg <= 8'd1) begin
                    state_next   = RUN;
                    rst_cnt_next = '0;
                    count_next   = '0;
                end else begin
                    rst_cnt_next = rst_cnt_reg - 8'd1;
                end
            end
            RUN: begin
                // halt takes priority over budget exhaustion; the count never passes LAST_COUNT.
                if (halt) begin
                    state_next   = DONE;
                    timeout_next = 1'b0;
                end else if (count_reg == LAST_COUNT) begin
                    state_next   = DONE;
                    timeout_next = 1'b1;
                end else begin
                    count_next = count_reg + CNT_W'(1);
                end
            end
            DONE: begin
                if (clear) begin
                    state_next   = IDLE;
                    count_next   = '0;
                    timeout_next = 1'b0;
                end
            end
            default: begin
                state_next   = IDLE;
                count_next   = '0;
                timeout_next = 1'b0;
            end
        endcase

        // Status flags are registered from the next state so they change on the same edge.
        core_rst_next = (state_next != RUN);
        running_next  = (state_next == RUN);
        done_next     = (state_next == DONE);
    end

    assign core_rst    = core_rst_reg;
    assign running     = running_reg;
    assign done        = done_reg;
    assign timeout     = timeout_reg;
    assign cycle_count = count_reg;

endmodule
